// File: rtl/pixel_bus_pkg.sv
// Shared types and constants for the pixel write bus slave.
//   drain_state_t : SRAM drain FSM states
//   fifo_entry_t  : one buffered pixel write (word address + colour)
package pixel_bus_pkg;

  localparam int unsigned RGB_W   = 24;
  localparam int unsigned BUS_AW  = 32;
  // Byte address minus the two byte-select bits.
  localparam int unsigned WORD_AW = BUS_AW - 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD
  } drain_state_t;

  typedef struct packed {
    logic [WORD_AW-1:0] word_addr;
    logic [RGB_W-1:0]   rgb;
  } fifo_entry_t;

endpackage

// File: rtl/pixel_write_slave_if.sv
// Pixel write bus between the renderer memory controller (master) and the
// frame-buffer slave.
//   addr     : byte address of the pixel
//   rgb_data : pixel colour {R,G,B}
//   wenable  : write request, held by the master while buswait is high
//   buswait  : slave busy, the write is not taken this cycle
interface pixel_write_slave_if;
  import pixel_bus_pkg::*;

  logic [BUS_AW-1:0] addr;
  logic [RGB_W-1:0]  rgb_data;
  logic              wenable;
  logic              buswait;

  modport master (output addr, output rgb_data, output wenable, input buswait);
  modport slave  (input addr, input rgb_data, input wenable, output buswait);

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel writes.
//   clk, n_rst : clock, asynchronous active-low reset
//   push_i     : write wdata_i (never asserted while full)
//   pop_i      : drop the head entry (never asserted while empty)
//   head_o     : current head, combinational from the registered array
//   next_o     : entry behind the head, valid when count_o >= 2
//   full_o, empty_o, count_o : occupancy
module pixel_fifo
  import pixel_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  fifo_entry_t wdata_i,
  output fifo_entry_t head_o,
  output fifo_entry_t next_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [CW-1:0] count_o
);

  fifo_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Pointers are PW bits wide, so the +1 wraps modulo DEPTH.
  assign rd_nxt  = rd_ptr_q + 1'b1;
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_nxt];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pixel_write_slave.sv
// Pixel write bus slave: buffers writes in a FIFO and drains them into an
// asynchronous frame-buffer SRAM with a fixed SETUP / WRITE / HOLD cycle.
//   clk, n_rst     : clock, asynchronous active-low reset
//   bus            : pixel write bus (slave side)
//   sram_*         : SRAM pins; strobes active low, all registered
//   stat_accepted  : saturating count of in-window writes
//   stat_dropped   : saturating count of out-of-window writes
// Optional: define STATS_EN to build the statistics counters; without it
// the stat ports are tied to zero.
module pixel_write_slave
  import pixel_bus_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       SRAM_AW    = 19,
  parameter int unsigned       SRAM_WAIT  = 2,
  parameter logic [BUS_AW-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                n_rst,
  pixel_write_slave_if.slave  bus,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [RGB_W-1:0]    sram_data,
  output logic                sram_we_n,
  output logic                sram_ce_n,
  output logic [15:0]         stat_accepted,
  output logic [15:0]         stat_dropped
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WCW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

  logic          in_window, accept, push, pop, full, empty;
  logic [CW-1:0] count;
  fifo_entry_t   wr_entry, head, next_head, load_entry;

  // buswait comes from the registered count only; no path from bus inputs.
  assign in_window = (bus.addr[BUS_AW-1:SRAM_AW+2] == BASE_ADDR[BUS_AW-1:SRAM_AW+2]);
  assign accept    = bus.wenable & ~full;
  assign push      = accept & in_window;
  assign bus.buswait = full;

  assign wr_entry.word_addr = WORD_AW'(bus.addr[SRAM_AW+1:2]);
  assign wr_entry.rgb       = bus.rgb_data;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .head_o  (head),
    .next_o  (next_head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  drain_state_t     state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             we_n_q, we_n_d, ce_n_q, ce_n_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [RGB_W-1:0]   data_q, data_d;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    we_n_d     = 1'b1;
    ce_n_d     = ce_n_q;
    addr_d     = addr_q;
    data_d     = data_q;
    pop        = 1'b0;
    load_entry = head;
    unique case (state_q)
      IDLE: begin
        ce_n_d = 1'b1;
        if (!empty) begin
          state_d = SETUP;
          ce_n_d  = 1'b0;
          addr_d  = head.word_addr[SRAM_AW-1:0];
          data_d  = head.rgb;
        end
      end
      SETUP: begin
        state_d = WRITE;
        we_n_d  = 1'b0;
        wait_d  = WCW'(SRAM_WAIT - 1);
      end
      WRITE: begin
        if (wait_q == '0) begin
          state_d = HOLD;
        end else begin
          wait_d = wait_q - 1'b1;
          we_n_d = 1'b0;
        end
      end
      HOLD: begin
        pop = 1'b1;
        // Registered outputs are loaded on the way into SETUP, so the entry
        // that becomes head after this pop is picked here: the one behind
        // the head, or the write being pushed into a one-entry FIFO.
        if (count > CW'(1) || push) begin
          load_entry = (count > CW'(1)) ? next_head : wr_entry;
          state_d    = SETUP;
          addr_d     = load_entry.word_addr[SRAM_AW-1:0];
          data_d     = load_entry.rgb;
        end else begin
          state_d = IDLE;
          ce_n_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      we_n_q  <= 1'b1;
      ce_n_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      we_n_q  <= we_n_d;
      ce_n_q  <= ce_n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign sram_addr = addr_q;
  assign sram_data = data_q;
  assign sram_we_n = we_n_q;
  assign sram_ce_n = ce_n_q;

`ifdef STATS_EN
  logic [15:0] acc_q, acc_d, drop_q, drop_d;

  always_comb begin
    acc_d  = acc_q;
    drop_d = drop_q;
    if (push && acc_q != 16'hFFFF) begin
      acc_d = acc_q + 16'd1;
    end
    if (accept && !in_window && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_dropped  = drop_q;
`else
  assign stat_accepted = '0;
  assign stat_dropped  = '0;
`endif

  // Byte-select bits and address bits above the SRAM window are not stored.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[1:0], head.word_addr[WORD_AW-1:SRAM_AW],
                         next_head.word_addr[WORD_AW-1:SRAM_AW],
                         load_entry.word_addr[WORD_AW-1:SRAM_AW]};

endmodule
